// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state and master-id types for the data-RAM arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RESP} arb_state_t;
  typedef logic mst_id_t;
  localparam mst_id_t MST_CORE = 1'b0;
  localparam mst_id_t MST_DMA  = 1'b1;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: 2-way request picker; round-robin, or fixed m0 priority under DMEM_ARB_FIXED_PRIO_EN.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output mst_id_t    gnt_id
);
`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused;
  assign unused = &{clk, rst_n, advance};
  assign gnt_id = req[0] ? MST_CORE : (req[1] ? MST_DMA : MST_CORE);
`else
  mst_id_t ptr_q, ptr_d;
  always_comb begin
    gnt_id = (req[0] & req[1]) ? ptr_q : (req[1] ? MST_DMA : MST_CORE);
    ptr_d  = (advance & |req) ? ~gnt_id : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= !rst_n ? MST_CORE : ptr_d;
`endif
  assign gnt = {2{|req}} & (gnt_id ? 2'b10 : 2'b01);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one fixed-latency RAM between core (m0) and DMA (m1); DMEM_ARB_FIXED_PRIO_EN selects fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_req_ready,
  output logic                m0_rsp_valid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_req_ready,
  output logic                m1_rsp_valid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int CW = $clog2(MEM_LAT + 1);
  arb_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  mst_id_t           id_q, id_d, gnt_id;
  logic              we_q, we_d, accept, sel_we, rsp, unused;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt;
  assign unused = ^{m0_addr[1:0], m1_addr[1:0]};
  dmem_rr_pick u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({m1_req_valid, m0_req_valid}),
    .advance (accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );
  always_comb begin
    accept  = (state_q == ARB_IDLE) & (m0_req_valid | m1_req_valid);
    sel_we  = gnt_id ? m1_we : m0_we;
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    if (accept) begin
      state_d = ARB_WAIT;
      cnt_d   = CW'(MEM_LAT - 1);
      id_d    = gnt_id;
      we_d    = sel_we;
    end else if (state_q == ARB_WAIT) begin
      if (cnt_q == '0) begin
        state_d = ARB_RESP;
        rdata_d = we_q ? '0 : mem_rdata;
      end else cnt_d = cnt_q - CW'(1);
    end else if (state_q == ARB_RESP) state_d = ARB_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      id_q    <= MST_CORE;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end
  // RAM strobes come straight from the winner in the accept cycle and are zero otherwise
  assign m0_req_ready = accept & gnt[0];
  assign m1_req_ready = accept & gnt[1];
  assign mem_en       = accept;
  assign mem_we       = accept & sel_we;
  assign mem_wstrb    = mem_we ? (gnt_id ? m1_wstrb : m0_wstrb) : '0;
  assign mem_addr     = accept ? {(gnt_id ? m1_addr[ADDR_W-1:2] : m0_addr[ADDR_W-1:2]), 2'b00} : '0;
  assign mem_wdata    = accept ? (gnt_id ? m1_wdata : m0_wdata) : '0;
  assign rsp          = state_q == ARB_RESP;
  assign m0_rsp_valid = rsp & (id_q == MST_CORE);
  assign m1_rsp_valid = rsp & (id_q == MST_DMA);
  assign m0_rdata     = m0_rsp_valid ? rdata_q : '0;
  assign m1_rdata     = m1_rsp_valid ? rdata_q : '0;
  assign busy         = state_q != ARB_IDLE;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;
  localparam int LAT = 1;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic m0_req_valid, m0_we, m0_req_ready, m0_rsp_valid;
  logic m1_req_valid, m1_we, m1_req_ready, m1_rsp_valid;
  logic [3:0] m0_wstrb, m1_wstrb, mem_wstrb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic b_req_valid, b_ready, b_rsp_valid, b_m1_ready, b_m1_rsp, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_addr, b_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0] b_mem_wstrb;
  int errs = 0, checks = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wstrb(m0_wstrb),
    .m0_wdata(m0_wdata), .m0_req_ready(m0_req_ready), .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wstrb(m1_wstrb),
    .m1_wdata(m1_wdata), .m1_req_ready(m1_req_ready), .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(b_req_valid), .m0_addr(b_addr), .m0_we(1'b0), .m0_wstrb(4'h0),
    .m0_wdata(32'h0), .m0_req_ready(b_ready), .m0_rsp_valid(b_rsp_valid), .m0_rdata(b_rdata),
    .m1_req_valid(1'b0), .m1_addr(32'h0), .m1_we(1'b0), .m1_wstrb(4'h0),
    .m1_wdata(32'h0), .m1_req_ready(b_m1_ready), .m1_rsp_valid(b_m1_rsp), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_wstrb(b_mem_wstrb), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Behavioural RAMs: 1-cycle for u_dut, 3-stage read pipe for u_dut3; pl_* is a backdoor preload
  logic [31:0] ram [0:63];
  logic [31:0] ram_b [0:15];
  logic [31:0] rd_q, s1, s2, s3, pl_val;
  logic pl_en = 0;
  logic [5:0] pl_idx;
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_idx] <= pl_val;
      ram_b[pl_idx[3:0]] <= pl_val;
    end
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_wstrb[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else rd_q <= ram[mem_addr[7:2]];
    end
    if (b_mem_en) s1 <= ram_b[b_mem_addr[5:2]];
    s2 <= s1;
    s3 <= s2;
  end
  assign mem_rdata = rd_q;
  assign b_mem_rdata = s3;

  task automatic drive0(input logic v, input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    m0_req_valid = v; m0_addr = a; m0_we = w; m0_wstrb = s; m0_wdata = d;
  endtask
  task automatic drive1(input logic v, input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    m1_req_valid = v; m1_addr = a; m1_we = w; m1_wstrb = s; m1_wdata = d;
  endtask
  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk); pl_en = 1; pl_idx = idx; pl_val = val;
    @(negedge clk); pl_en = 0;
  endtask

  task automatic test_reset;
    logic [199:0] obs;
    rst_n = 0; b_req_valid = 0; b_addr = 0;
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    obs = {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, mem_en, mem_we, busy, b_busy,
           mem_wstrb, mem_addr, mem_wdata, m0_rdata, m1_rdata, b_rdata, 4'h0};
    checks++; if (obs !== '0) begin errs++; $display("FAIL reset_outputs: got %h want 0", obs); end
    rst_n = 1;
  endtask

  task automatic test_read;
    preload(4, 32'hDEADBEEF);
    @(negedge clk); drive0(1, 32'h13, 0, 4'hF, 32'h5555_5555); #1;
    checks++;
    if ({m0_req_ready, m1_req_ready, mem_en, mem_we, mem_wstrb, mem_addr, busy} !== {4'b1010, 4'h0, 32'h10, 1'b0}) begin
      errs++; $display("FAIL read_accept: got %b %b %b %b %h %h %b want 1 0 1 0 0 00000010 0",
                       m0_req_ready, m1_req_ready, mem_en, mem_we, mem_wstrb, mem_addr, busy);
    end
    @(negedge clk); drive0(0, 0, 0, 0, 0); #1;
    checks++; if ({busy, mem_en, m0_rsp_valid, m1_rsp_valid} !== 4'b1000) begin
      errs++; $display("FAIL read_wait: got %b want 1000", {busy, mem_en, m0_rsp_valid, m1_rsp_valid}); end
    @(negedge clk); #1;
    checks++; if ({busy, m0_rsp_valid, m1_rsp_valid, m0_rdata} !== {3'b110, 32'hDEADBEEF}) begin
      errs++; $display("FAIL read_rsp: got %b%b%b %h want 110 deadbeef", busy, m0_rsp_valid, m1_rsp_valid, m0_rdata); end
    @(negedge clk); #1;
    checks++; if ({busy, m0_rsp_valid} !== 2'b00) begin
      errs++; $display("FAIL read_idle: got %b want 00", {busy, m0_rsp_valid}); end
  endtask

  task automatic test_write;
    preload(2, 32'h1122_3344);
    @(negedge clk); drive1(1, 32'h8, 1, 4'b1100, 32'hEF01_0000); #1;
    checks++;
    if ({m1_req_ready, m0_req_ready, mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata} !== {4'b1011, 4'b1100, 32'h8, 32'hEF01_0000}) begin
      errs++; $display("FAIL write_accept: got %b%b%b%b %b %h %h want 1011 1100 00000008 ef010000",
                       m1_req_ready, m0_req_ready, mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata);
    end
    @(negedge clk); drive1(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    checks++; if ({m1_rsp_valid, m0_rsp_valid, m1_rdata} !== {2'b10, 32'h0}) begin
      errs++; $display("FAIL write_rsp: got %b%b %h want 10 00000000", m1_rsp_valid, m0_rsp_valid, m1_rdata); end
    @(negedge clk); drive0(1, 32'h8, 0, 4'h0, 32'h0); #1;
    checks++; if (m0_req_ready !== 1'b1) begin errs++; $display("FAIL readback_accept: got %b want 1", m0_req_ready); end
    @(negedge clk); drive0(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    checks++; if ({m0_rsp_valid, m0_rdata} !== {1'b1, 32'hEF01_3344}) begin
      errs++; $display("FAIL readback_data: got %b %h want 1 ef013344", m0_rsp_valid, m0_rdata); end
  endtask

  task automatic test_back_to_back;
    int last_t = -1, n = 0;
    logic id, last_id = 0, exp_id;
    @(negedge clk);
    drive0(1, 32'h0, 0, 0, 0); drive1(1, 32'h4, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (m0_req_ready | m1_req_ready) begin
        id = m1_req_ready;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_id = 1'b0;
`else
        exp_id = (n == 0) ? 1'b1 : ~last_id;
`endif
        checks++;
        if ((m0_req_ready & m1_req_ready) || id !== exp_id || (n > 0 && c - last_t != 3)) begin
          errs++; $display("FAIL contention_grant%0d: got ready=%b%b gap=%0d want id=%b gap=3",
                           n, m1_req_ready, m0_req_ready, c - last_t, exp_id);
        end
        last_t = c; last_id = id; n++;
      end
      @(negedge clk);
    end
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    checks++; if (n != 7) begin errs++; $display("FAIL contention_count: got %0d want 7", n); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency3;
    preload(5, 32'hCAFE_0005);
    @(negedge clk); b_req_valid = 1; b_addr = 32'h14; #1;
    checks++; if ({b_ready, b_mem_en, b_mem_addr} !== {2'b11, 32'h14}) begin
      errs++; $display("FAIL lat3_accept: got %b%b %h want 11 00000014", b_ready, b_mem_en, b_mem_addr); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({b_ready, b_mem_en, b_rsp_valid, b_busy} !== {k == 5, k == 5, k == 4, k < 5}) begin
        errs++; $display("FAIL lat3_t%0d: got %b want %b", k, {b_ready, b_mem_en, b_rsp_valid, b_busy},
                         {k == 5, k == 5, k == 4, k < 5});
      end
      if (k == 4) begin
        checks++; if (b_rdata !== 32'hCAFE_0005) begin errs++; $display("FAIL lat3_data: got %h want cafe0005", b_rdata); end
      end
    end
    b_req_valid = 0;
  endtask

  task automatic test_reset_wait;
    logic [163:0] obs;
    @(negedge clk); drive0(1, 32'h10, 0, 0, 0); #1;
    checks++; if (m0_req_ready !== 1'b1) begin errs++; $display("FAIL rstw_accept: got %b want 1", m0_req_ready); end
    @(negedge clk); drive0(0, 0, 0, 0, 0); rst_n = 0;
    @(negedge clk); rst_n = 1; #1;
    obs = {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, busy, mem_en, mem_we, 1'b0,
           mem_wstrb, mem_addr, mem_wdata, m0_rdata, m1_rdata};
    checks++; if (obs !== '0) begin errs++; $display("FAIL rstw_outputs: got %h want 0", obs); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if ({m0_rsp_valid, m1_rsp_valid, busy} !== 3'b000) begin
        errs++; $display("FAIL rstw_no_rsp%0d: got %b want 000", k, {m0_rsp_valid, m1_rsp_valid, busy}); end
    end
    @(negedge clk); drive0(1, 32'h10, 0, 0, 0); #1;
    checks++; if (m0_req_ready !== 1'b1) begin errs++; $display("FAIL rstw_reaccept: got %b want 1", m0_req_ready); end
    @(negedge clk); drive0(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    checks++; if ({m0_rsp_valid, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errs++; $display("FAIL rstw_rsp: got %b %h want 1 deadbeef", m0_rsp_valid, m0_rdata); end
  endtask

  task automatic test_drop;
    preload(6, 32'h89AB_CD12);
    @(negedge clk); drive0(1, 32'h0, 0, 0, 0); #1;
    checks++; if (m0_req_ready !== 1'b1) begin errs++; $display("FAIL drop_m0_accept: got %b want 1", m0_req_ready); end
    @(negedge clk); drive0(0, 0, 0, 0, 0); drive1(1, 32'h18, 1, 4'hF, 32'h0); #1;
    checks++; if ({m1_req_ready, mem_en} !== 2'b00) begin
      errs++; $display("FAIL drop_busy_ready: got %b want 00", {m1_req_ready, mem_en}); end
    @(negedge clk); drive1(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({m1_req_ready, m1_rsp_valid} !== 2'b00) begin
        errs++; $display("FAIL drop_m1_quiet%0d: got %b want 00", k, {m1_req_ready, m1_rsp_valid}); end
      @(negedge clk);
    end
    drive0(1, 32'h18, 0, 0, 0); #1;
    @(negedge clk); drive0(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    checks++; if ({m0_rsp_valid, m0_rdata} !== {1'b1, 32'h89AB_CD12}) begin
      errs++; $display("FAIL drop_ram_intact: got %b %h want 1 89abcd12", m0_rsp_valid, m0_rdata); end
  endtask

  task automatic test_random;
    logic [31:0] mm [0:15];
    logic pend [2], rw [2];
    logic [31:0] ra [2], rd [2];
    logic [3:0] rs [2];
    logic [31:0] v, rdat = 0;
    logic lw = 1'b1, w, idle, acc, r, rid = 0;
    int cyc = 0, free_at = 0, due = -1;
    @(negedge clk); rst_n = 0; drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 16; i++) begin v = $urandom; preload(6'(i), v); mm[i] = v; end
    for (int i = 0; i < 2; i++) begin pend[i] = 0; rw[i] = 0; ra[i] = 0; rd[i] = 0; rs[i] = 0; end
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; ra[i] = 32'($urandom_range(0, 63)); rw[i] = 1'($urandom_range(0, 1));
          rs[i] = 4'($urandom); rd[i] = $urandom;
        end
      end
      drive0(pend[0], ra[0], rw[0], rs[0], rd[0]);
      drive1(pend[1], ra[1], rw[1], rs[1], rd[1]);
      #1;
      idle = cyc >= free_at;
      acc = idle && (pend[0] || pend[1]);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      w = !pend[0];
`else
      w = (pend[0] && pend[1]) ? ~lw : pend[1];
`endif
      checks++;
      if ({m0_req_ready, m1_req_ready, mem_en, busy} !== {acc && !w, acc && w, acc, !idle}) begin
        errs++; $display("FAIL rnd_ctrl cyc%0d: got %b want %b", cyc, {m0_req_ready, m1_req_ready, mem_en, busy},
                         {acc && !w, acc && w, acc, !idle});
      end
      checks++;
      if (acc ? ({mem_we, mem_wstrb, mem_addr} !== {rw[w], rw[w] ? rs[w] : 4'h0, ra[w] & ~32'h3}) ||
                (rw[w] && mem_wdata !== rd[w])
              : ({mem_we, mem_wstrb, mem_addr, mem_wdata} !== '0)) begin
        errs++; $display("FAIL rnd_mem cyc%0d: got we=%b strb=%h addr=%h wdata=%h", cyc, mem_we, mem_wstrb, mem_addr, mem_wdata);
      end
      r = cyc == due;
      checks++;
      if ({m0_rsp_valid, m1_rsp_valid} !== {r && !rid, r && rid} || (r && (rid ? m1_rdata : m0_rdata) !== rdat)) begin
        errs++; $display("FAIL rnd_rsp cyc%0d: got %b %h %h want %b data %h", cyc, {m0_rsp_valid, m1_rsp_valid},
                         m0_rdata, m1_rdata, {r && !rid, r && rid}, rdat);
      end
      if (acc) begin
        lw = w; rid = w; free_at = cyc + LAT + 2; due = cyc + LAT + 1;
        rdat = rw[w] ? 32'h0 : mm[ra[w][5:2]];
        if (rw[w]) for (int b = 0; b < 4; b++) if (rs[w][b]) mm[ra[w][5:2]][8*b +: 8] = rd[w][8*b +: 8];
        pend[w] = 0;
      end
      cyc++;
    end
    drive0(0, 0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_latency3();
    test_reset_wait();
    test_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
